wbnpriarb: RTL and testbench
============================

Name: wbnpriarb

Overview:
- Parametrised N-master Wishbone arbiter, successor to the two-master priority arbiter in the CPU wrapper.
- Merges NM masters onto one shared bus with split global/local cycle and strobe lines, e.g. prefetch, data memory and a debug/DMA port.
- Arbitration is either fixed priority or round robin.
- Adds grant locking for the whole bus cycle, an optional idle-zeroing of outputs, and per-master grant/busy status.

Parameters:
- NM, 3, number of masters; master 0 has highest fixed priority.
- AW, 30, word address width.
- DW, 32, data width; select width is DW/8.
- OPT_RR, 0, 1 selects round robin, 0 selects fixed priority (lowest index wins).
- OPT_ZERO_ON_IDLE, 0, 1 forces o_addr, o_data and o_sel to zero when no master is granted.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_cyc_gbl  in  NM  per-master global cycle
- i_cyc_lcl  in  NM  per-master local cycle
- i_stb_gbl  in  NM  per-master global strobe
- i_stb_lcl  in  NM  per-master local strobe
- i_we  in  NM  per-master write enable
- i_addr  in  NM*AW  flattened addresses; master k occupies [k*AW +: AW]
- i_data  in  NM*DW  flattened write data
- i_sel  in  NM*DW/8  flattened byte selects
- o_stall  out  NM  per-master stall
- o_ack  out  NM  per-master ack
- o_err  out  NM  per-master err
- o_wb_gbl_cyc, o_wb_lcl_cyc, o_wb_gbl_stb, o_wb_lcl_stb, o_wb_we  out  1 each  shared bus controls
- o_wb_addr  out  AW  shared address
- o_wb_data  out  DW  shared write data
- o_wb_sel  out  DW/8  shared byte select
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  slave responses
- o_grant  out  NM  one-hot current owner, all zero when idle
- o_busy  out  1  a master owns the bus

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset_n is asynchronous and active-low.
- State: r_grant_valid, r_grant_idx (LGNM bits), r_last_idx (round-robin pointer).
- Reset: r_grant_valid=0 and r_last_idx=NM-1. Consequently o_grant=0, o_busy=0, all bus cyc/stb/we=0, o_stall=all ones, o_ack=0, o_err=0.
- Request: req[k] = i_cyc_gbl[k] | i_cyc_lcl[k].
- States: IDLE (!r_grant_valid) and OWNED (r_grant_valid).
- IDLE, at a clock edge with any req set: grant the winner and move to OWNED. The winner's cyc appears on the bus in the next cycle, so arbitration latency is one cycle.
- OWNED, at a clock edge where the owner's req is low: release.
  - If other requests are present, re-arbitrate in the same edge and stay OWNED with the new index; otherwise go to IDLE.
  - The bus therefore always sees at least one cycle with cyc low between owners.
- The grant never changes while the owner's req is high, so locked and multi-beat cycles are preserved.
- Fixed priority: winner is the lowest-index req.
- Round robin: winner is the first req scanning from r_last_idx+1 upward, wrapping modulo NM. r_last_idx is updated to the winner on every grant.
- Datapath (combinational from the registered grant):
  - When granted, o_wb_* = the owner's signals, with cyc and stb gated by r_grant_valid.
  - Non-owners see o_stall=1, o_ack=0, o_err=0.
  - The owner sees o_stall=i_wb_stall, o_ack=i_wb_ack, o_err=i_wb_err.
- Slave responses: i_wb_ack or i_wb_err arriving while IDLE is discarded.
- A master asserting both gbl and lcl is illegal. Both are forwarded and an assertion flags it.
- Abandoned cycles: if the owner drops cyc with responses outstanding, late acks in the next cycle are routed to the new owner. This is legal per the codebase bus rules, because slaves drop state on cyc low.
- When not granted, o_wb_addr/data/sel follow master 0 unless OPT_ZERO_ON_IDLE=1, in which case they are zero.
- Reset asserted mid-cycle: grant clears immediately (asynchronous) and all cyc outputs drop.
- NM=1: the grant is the single master; the arbiter degenerates to one-cycle acquisition.

Decomposition:
- Shared package (wbarb_pkg) holds:
  - LGNM = $clog2(NM), minimum 1.
  - Function slice helpers for flattened buses.
- One natural sub-module: wbarb_pick.
  - Inputs: req vector, start index, OPT_RR.
  - Outputs: winner index and any-request.
  - It is purely combinational and is reused by future crossbars.

Test Plan:
- Reset then idle: after release o_stall=3'b111, o_busy=0, o_wb_gbl_cyc=0. Assert i_cyc_gbl=3'b010 -> next cycle o_grant=3'b010, o_stall[1]=i_wb_stall, bus addr = master 1 address.
- Fixed priority: req 3'b110 simultaneously -> master 1 granted. Master 1 holds cyc for 5 cycles while master 0 requests -> master 0 granted only on the edge after master 1 drops cyc, with exactly one cyc-low cycle between.
- Round robin (OPT_RR=1): all three request continuously, each releasing after 2 acks -> grant order 0,1,2,0. Never two consecutive grants to the same master while others wait.
- Ack routing: owner 2 issues 4 pipelined reads and slave acks 4 times -> o_ack[2] pulses 4 times, o_ack[0] and o_ack[1] stay 0. A slave ack while idle changes no output.
- Local bus: master 0 drives i_cyc_lcl=1, i_stb_lcl=1 -> o_wb_lcl_cyc=1 and o_wb_gbl_cyc=0. i_wb_err -> o_err[0]=1 for that cycle.
- Asynchronous reset mid-transfer: drop i_reset_n between clock edges while owned -> o_wb_gbl_cyc=0 and o_grant=0 without waiting for a clock edge.

Source files
------------

// File: rtl/wbarb_pkg.sv
// Shared definitions for the Wishbone arbiter family: arbitration states,
// index-width helper and flattened-bus slice helper.
package wbarb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Index width for n masters, never narrower than one bit
  function automatic int lg_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Low bit of element k in a flattened bus of w-bit elements
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/wbarb_pick.sv
// Combinational winner selection: lowest-index fixed priority, or round robin
// scanning upward from the entry after last_idx.
module wbarb_pick
  import wbarb_pkg::*;
#(
  parameter int NM     = 3,
  parameter int LGNM   = lg_min1(NM),
  parameter bit OPT_RR = 1'b0
) (
  input  logic [NM-1:0]   req,
  input  logic [LGNM-1:0] last_idx,
  output logic [LGNM-1:0] win_idx,
  output logic            any_req
);

  logic found;
  int   cand;

  always_comb begin
    win_idx = '0;
    any_req = |req;
    found   = 1'b0;
    cand    = 0;
    if (OPT_RR) begin
      for (int i = 1; i <= NM; i++) begin
        cand = (int'(last_idx) + i) % NM;
        if (!found && req[LGNM'(cand)]) begin
          found   = 1'b1;
          win_idx = LGNM'(cand);
        end
      end
    end else begin
      // Descending scan so the lowest requesting index is written last
      for (int k = NM - 1; k >= 0; k--) begin
        if (req[LGNM'(k)]) win_idx = LGNM'(k);
      end
    end
  end

endmodule

// File: rtl/wbnpriarb.sv
// N-master Wishbone arbiter with split global/local cycle and strobe lines.
// The grant is held for the owner's whole bus cycle.
module wbnpriarb
  import wbarb_pkg::*;
#(
  parameter int NM               = 3,
  parameter int AW               = 30,
  parameter int DW               = 32,
  parameter bit OPT_RR           = 1'b0,
  parameter bit OPT_ZERO_ON_IDLE = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NM-1:0]      i_cyc_gbl,
  input  logic [NM-1:0]      i_cyc_lcl,
  input  logic [NM-1:0]      i_stb_gbl,
  input  logic [NM-1:0]      i_stb_lcl,
  input  logic [NM-1:0]      i_we,
  input  logic [NM*AW-1:0]   i_addr,
  input  logic [NM*DW-1:0]   i_data,
  input  logic [NM*DW/8-1:0] i_sel,
  output logic [NM-1:0]      o_stall,
  output logic [NM-1:0]      o_ack,
  output logic [NM-1:0]      o_err,
  output logic               o_wb_gbl_cyc,
  output logic               o_wb_lcl_cyc,
  output logic               o_wb_gbl_stb,
  output logic               o_wb_lcl_stb,
  output logic               o_wb_we,
  output logic [AW-1:0]      o_wb_addr,
  output logic [DW-1:0]      o_wb_data,
  output logic [DW/8-1:0]    o_wb_sel,
  input  logic               i_wb_stall,
  input  logic               i_wb_ack,
  input  logic               i_wb_err,
  output logic [NM-1:0]      o_grant,
  output logic               o_busy
);

  localparam int LGNM = lg_min1(NM);
  localparam int SW   = DW / 8;

  arb_state_t      r_state, next_state;
  logic            r_grant_valid;
  logic [LGNM-1:0] r_grant_idx, next_idx;
  logic [LGNM-1:0] r_last_idx, next_last;
  logic [LGNM-1:0] win_idx;
  logic [NM-1:0]   req;
  logic            any_req;
  logic            owner_req;

  assign req           = i_cyc_gbl | i_cyc_lcl;
  assign owner_req     = req[r_grant_idx];
  assign r_grant_valid = (r_state == ST_OWNED);
  assign o_busy        = r_grant_valid;

  wbarb_pick #(
    .NM    (NM),
    .LGNM  (LGNM),
    .OPT_RR(OPT_RR)
  ) u_pick (
    .req     (req),
    .last_idx(r_last_idx),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= LGNM'(NM - 1);
    end else begin
      r_state     <= next_state;
      r_grant_idx <= next_idx;
      r_last_idx  <= next_last;
    end
  end

  // While the owner still requests, the pick result is ignored; once it
  // drops, the owner is absent from req so the pick covers only the others.
  always_comb begin
    next_state = r_state;
    next_idx   = r_grant_idx;
    next_last  = r_last_idx;
    case (r_state)
      ST_IDLE: begin
        if (any_req) begin
          next_state = ST_OWNED;
          next_idx   = win_idx;
          next_last  = win_idx;
        end
      end
      ST_OWNED: begin
        if (!owner_req) begin
          if (any_req) begin
            next_idx  = win_idx;
            next_last = win_idx;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_grant      = '0;
    o_stall      = '1;
    o_ack        = '0;
    o_err        = '0;
    o_wb_gbl_cyc = 1'b0;
    o_wb_lcl_cyc = 1'b0;
    o_wb_gbl_stb = 1'b0;
    o_wb_lcl_stb = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_addr    = OPT_ZERO_ON_IDLE ? '0 : i_addr[AW-1:0];
    o_wb_data    = OPT_ZERO_ON_IDLE ? '0 : i_data[DW-1:0];
    o_wb_sel     = OPT_ZERO_ON_IDLE ? '0 : i_sel[SW-1:0];
    if (r_grant_valid) begin
      o_grant[r_grant_idx] = 1'b1;
      o_stall[r_grant_idx] = i_wb_stall;
      o_ack[r_grant_idx]   = i_wb_ack;
      o_err[r_grant_idx]   = i_wb_err;
      o_wb_gbl_cyc         = i_cyc_gbl[r_grant_idx];
      o_wb_lcl_cyc         = i_cyc_lcl[r_grant_idx];
      o_wb_gbl_stb         = i_stb_gbl[r_grant_idx];
      o_wb_lcl_stb         = i_stb_lcl[r_grant_idx];
      o_wb_we              = i_we[r_grant_idx];
      o_wb_addr            = i_addr[slice_lo(int'(r_grant_idx), AW) +: AW];
      o_wb_data            = i_data[slice_lo(int'(r_grant_idx), DW) +: DW];
      o_wb_sel             = i_sel[slice_lo(int'(r_grant_idx), SW) +: SW];
    end
  end

  // A master may drive the global or the local bus, never both at once
  a_no_dual_bus : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    ((i_cyc_gbl & i_cyc_lcl) | (i_stb_gbl & i_stb_lcl)) == '0);

endmodule

// File: tb/tb_wbnpriarb.sv
// Bench for wbnpriarb: a fixed-priority instance and a round-robin instance
// with idle zeroing share one set of master/slave stimulus.
module tb_wbnpriarb;

  localparam int NM = 3;
  localparam int AW = 30;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n;
  logic [NM-1:0]       cyc_gbl, cyc_lcl, stb_gbl, stb_lcl, we;
  logic [NM*AW-1:0]    addr;
  logic [NM*DW-1:0]    data;
  logic [NM*DW/8-1:0]  sel;
  logic                wb_stall, wb_ack, wb_err;

  logic [NM-1:0]   f_stall, f_ack, f_err, f_grant;
  logic            f_gcyc, f_lcyc, f_gstb, f_lstb, f_we, f_busy;
  logic [AW-1:0]   f_addr;
  logic [DW-1:0]   f_data;
  logic [DW/8-1:0] f_sel;

  logic [NM-1:0]   r_stall, r_ack, r_err, r_grant;
  logic            r_gcyc, r_lcyc, r_gstb, r_lstb, r_we, r_busy;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic [DW/8-1:0] r_sel;

  wbnpriarb #(.NM(NM), .AW(AW), .DW(DW), .OPT_RR(1'b0), .OPT_ZERO_ON_IDLE(1'b0)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_cyc_gbl(cyc_gbl), .i_cyc_lcl(cyc_lcl), .i_stb_gbl(stb_gbl), .i_stb_lcl(stb_lcl),
    .i_we(we), .i_addr(addr), .i_data(data), .i_sel(sel),
    .o_stall(f_stall), .o_ack(f_ack), .o_err(f_err),
    .o_wb_gbl_cyc(f_gcyc), .o_wb_lcl_cyc(f_lcyc), .o_wb_gbl_stb(f_gstb), .o_wb_lcl_stb(f_lstb),
    .o_wb_we(f_we), .o_wb_addr(f_addr), .o_wb_data(f_data), .o_wb_sel(f_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_grant(f_grant), .o_busy(f_busy)
  );

  wbnpriarb #(.NM(NM), .AW(AW), .DW(DW), .OPT_RR(1'b1), .OPT_ZERO_ON_IDLE(1'b1)) dut_rr (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_cyc_gbl(cyc_gbl), .i_cyc_lcl(cyc_lcl), .i_stb_gbl(stb_gbl), .i_stb_lcl(stb_lcl),
    .i_we(we), .i_addr(addr), .i_data(data), .i_sel(sel),
    .o_stall(r_stall), .o_ack(r_ack), .o_err(r_err),
    .o_wb_gbl_cyc(r_gcyc), .o_wb_lcl_cyc(r_lcyc), .o_wb_gbl_stb(r_gstb), .o_wb_lcl_stb(r_lstb),
    .o_wb_we(r_we), .o_wb_addr(r_addr), .o_wb_data(r_data), .o_wb_sel(r_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_grant(r_grant), .o_busy(r_busy)
  );

  // src: index of the master whose address should be on the bus, 3 = zero
  typedef struct {
    bit         rr;
    logic [2:0] cg, cl;
    logic       ws, wa, we_;
    logic [2:0] e_grant, e_stall, e_ack, e_err;
    logic       e_gcyc, e_lcyc, e_busy;
    int         src;
  } vec_t;

  vec_t vecs_fix[$];
  vec_t vecs_rr[$];
  vec_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(bit rr, logic [2:0] cg, logic [2:0] cl, logic ws, logic wa,
                              logic we_, logic [2:0] g, logic [2:0] st, logic [2:0] ak,
                              logic [2:0] er, logic gc, logic lc, logic bs, int src);
    vec_t v;
    v.rr = rr; v.cg = cg; v.cl = cl; v.ws = ws; v.wa = wa; v.we_ = we_;
    v.e_grant = g; v.e_stall = st; v.e_ack = ak; v.e_err = er;
    v.e_gcyc = gc; v.e_lcyc = lc; v.e_busy = bs; v.src = src;
    return v;
  endfunction

  task automatic compare(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    else
      passed++;
  endtask

  task automatic applyStimulus(input vec_t v);
    cyc_gbl  = v.cg;
    stb_gbl  = v.cg;
    cyc_lcl  = v.cl;
    stb_lcl  = v.cl;
    wb_stall = v.ws;
    wb_ack   = v.wa;
    wb_err   = v.we_;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input int row);
    vec_t        v;
    logic [31:0] exp_addr;
    if (sb.size() == 0) begin
      compare("scoreboard_empty", row, 32'd1, 32'd0);
      return;
    end
    v = sb.pop_front();
    exp_addr = (v.src == 3) ? 32'h0 : 32'h100 + v.src;
    if (v.rr) begin
      compare("rr_grant", row, {29'b0, r_grant}, {29'b0, v.e_grant});
      compare("rr_stall", row, {29'b0, r_stall}, {29'b0, v.e_stall});
      compare("rr_ack",   row, {29'b0, r_ack},   {29'b0, v.e_ack});
      compare("rr_err",   row, {29'b0, r_err},   {29'b0, v.e_err});
      compare("rr_gcyc",  row, {31'b0, r_gcyc},  {31'b0, v.e_gcyc});
      compare("rr_gstb",  row, {31'b0, r_gstb},  {31'b0, v.e_gcyc});
      compare("rr_lcyc",  row, {31'b0, r_lcyc},  {31'b0, v.e_lcyc});
      compare("rr_busy",  row, {31'b0, r_busy},  {31'b0, v.e_busy});
      compare("rr_addr",  row, {2'b0, r_addr},   exp_addr);
    end else begin
      compare("grant", row, {29'b0, f_grant}, {29'b0, v.e_grant});
      compare("stall", row, {29'b0, f_stall}, {29'b0, v.e_stall});
      compare("ack",   row, {29'b0, f_ack},   {29'b0, v.e_ack});
      compare("err",   row, {29'b0, f_err},   {29'b0, v.e_err});
      compare("gcyc",  row, {31'b0, f_gcyc},  {31'b0, v.e_gcyc});
      compare("gstb",  row, {31'b0, f_gstb},  {31'b0, v.e_gcyc});
      compare("lcyc",  row, {31'b0, f_lcyc},  {31'b0, v.e_lcyc});
      compare("lstb",  row, {31'b0, f_lstb},  {31'b0, v.e_lcyc});
      compare("busy",  row, {31'b0, f_busy},  {31'b0, v.e_busy});
      compare("addr",  row, {2'b0, f_addr},   exp_addr);
    end
  endtask

  initial begin
    // Fixed priority: idle ack discarded, one-cycle acquisition, hold, priority, errors
    vecs_fix.push_back(mk(0, 3'b000, 3'b000, 0, 1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs_fix.push_back(mk(0, 3'b010, 3'b000, 1, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs_fix.push_back(mk(0, 3'b010, 3'b000, 1, 0, 0, 3'b010, 3'b111, 3'b000, 3'b000, 1, 0, 1, 1));
    vecs_fix.push_back(mk(0, 3'b010, 3'b000, 0, 0, 0, 3'b010, 3'b101, 3'b000, 3'b000, 1, 0, 1, 1));
    vecs_fix.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b010, 3'b101, 3'b000, 3'b000, 0, 0, 1, 1));
    vecs_fix.push_back(mk(0, 3'b110, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs_fix.push_back(mk(0, 3'b110, 3'b000, 0, 0, 0, 3'b010, 3'b101, 3'b000, 3'b000, 1, 0, 1, 1));
    vecs_fix.push_back(mk(0, 3'b001, 3'b000, 0, 0, 0, 3'b010, 3'b101, 3'b000, 3'b000, 0, 0, 1, 1));
    vecs_fix.push_back(mk(0, 3'b001, 3'b000, 0, 1, 0, 3'b001, 3'b110, 3'b001, 3'b000, 1, 0, 1, 0));
    vecs_fix.push_back(mk(0, 3'b001, 3'b000, 0, 0, 1, 3'b001, 3'b110, 3'b000, 3'b001, 1, 0, 1, 0));
    vecs_fix.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b001, 3'b110, 3'b000, 3'b000, 0, 0, 1, 0));
    // Local bus on master 0
    vecs_fix.push_back(mk(0, 3'b000, 3'b001, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs_fix.push_back(mk(0, 3'b000, 3'b001, 0, 0, 1, 3'b001, 3'b110, 3'b000, 3'b001, 0, 1, 1, 0));
    vecs_fix.push_back(mk(0, 3'b000, 3'b001, 0, 0, 0, 3'b001, 3'b110, 3'b000, 3'b000, 0, 1, 1, 0));
    vecs_fix.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b001, 3'b110, 3'b000, 3'b000, 0, 0, 1, 0));
    // Master 2 pipelined reads with four acks
    vecs_fix.push_back(mk(0, 3'b100, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs_fix.push_back(mk(0, 3'b100, 3'b000, 0, 0, 0, 3'b100, 3'b011, 3'b000, 3'b000, 1, 0, 1, 2));
    for (int i = 0; i < 4; i++)
      vecs_fix.push_back(mk(0, 3'b100, 3'b000, 0, 1, 0, 3'b100, 3'b011, 3'b100, 3'b000, 1, 0, 1, 2));
    vecs_fix.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b100, 3'b011, 3'b000, 3'b000, 0, 0, 1, 2));
    vecs_fix.push_back(mk(0, 3'b000, 3'b000, 0, 1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0));
    // Same-edge handover 0 -> 1; the late ack lands on the new owner
    vecs_fix.push_back(mk(0, 3'b001, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs_fix.push_back(mk(0, 3'b011, 3'b000, 0, 0, 0, 3'b001, 3'b110, 3'b000, 3'b000, 1, 0, 1, 0));
    vecs_fix.push_back(mk(0, 3'b010, 3'b000, 0, 0, 0, 3'b001, 3'b110, 3'b000, 3'b000, 0, 0, 1, 0));
    vecs_fix.push_back(mk(0, 3'b010, 3'b000, 0, 1, 0, 3'b010, 3'b101, 3'b010, 3'b000, 1, 0, 1, 1));
    vecs_fix.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 3'b010, 3'b101, 3'b000, 3'b000, 0, 0, 1, 1));
    vecs_fix.push_back(mk(0, 3'b100, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0));

    // Round robin from reset (pointer at 2): grant order 0,1,2,0, zeroed bus when idle
    vecs_rr.push_back(mk(1, 3'b111, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 3));
    vecs_rr.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b001, 3'b110, 3'b001, 3'b000, 1, 0, 1, 0));
    vecs_rr.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b001, 3'b110, 3'b001, 3'b000, 1, 0, 1, 0));
    vecs_rr.push_back(mk(1, 3'b110, 3'b000, 0, 0, 0, 3'b001, 3'b110, 3'b000, 3'b000, 0, 0, 1, 0));
    vecs_rr.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b010, 3'b101, 3'b010, 3'b000, 1, 0, 1, 1));
    vecs_rr.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b010, 3'b101, 3'b010, 3'b000, 1, 0, 1, 1));
    vecs_rr.push_back(mk(1, 3'b101, 3'b000, 0, 0, 0, 3'b010, 3'b101, 3'b000, 3'b000, 0, 0, 1, 1));
    vecs_rr.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b100, 3'b011, 3'b100, 3'b000, 1, 0, 1, 2));
    vecs_rr.push_back(mk(1, 3'b111, 3'b000, 0, 1, 0, 3'b100, 3'b011, 3'b100, 3'b000, 1, 0, 1, 2));
    vecs_rr.push_back(mk(1, 3'b011, 3'b000, 0, 0, 0, 3'b100, 3'b011, 3'b000, 3'b000, 0, 0, 1, 2));
    vecs_rr.push_back(mk(1, 3'b111, 3'b000, 0, 0, 0, 3'b001, 3'b110, 3'b000, 3'b000, 1, 0, 1, 0));
    vecs_rr.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 3'b001, 3'b110, 3'b000, 3'b000, 0, 0, 1, 0));
    vecs_rr.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 3));

    for (int k = 0; k < NM; k++) begin
      addr[k*AW +: AW]     = AW'(32'h100 + k);
      data[k*DW +: DW]     = 32'hD0 + k;
      sel[k*DW/8 +: DW/8]  = 4'hF;
    end
    we       = 3'b000;
    cyc_lcl  = 3'b000;
    stb_lcl  = 3'b000;
    wb_stall = 1'b0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    reset_n  = 1'b0;
    cyc_gbl  = 3'b111;
    stb_gbl  = 3'b111;

    // Requests held during reset must not produce a grant
    #7;
    compare("reset_grant", -1, {29'b0, f_grant}, 32'h0);
    compare("reset_stall", -1, {29'b0, f_stall}, 32'h7);
    compare("reset_busy",  -1, {31'b0, f_busy},  32'h0);
    compare("reset_gcyc",  -1, {31'b0, f_gcyc},  32'h0);
    compare("reset_rr_grant", -1, {29'b0, r_grant}, 32'h0);
    @(negedge clk);
    cyc_gbl = 3'b000;
    stb_gbl = 3'b000;
    reset_n = 1'b1;

    foreach (vecs_fix[i]) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs_fix[i]);
      @(negedge clk);
      checkOutput(i);
    end

    // Master 2 is granted at this edge, then reset drops between edges
    @(posedge clk);
    #1;
    compare("pre_areset_grant", 100, {29'b0, f_grant}, 32'h4);
    compare("pre_areset_gcyc",  100, {31'b0, f_gcyc},  32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    compare("areset_gcyc",     101, {31'b0, f_gcyc},  32'h0);
    compare("areset_grant",    101, {29'b0, f_grant}, 32'h0);
    compare("areset_busy",     101, {31'b0, f_busy},  32'h0);
    compare("areset_rr_grant", 101, {29'b0, r_grant}, 32'h0);
    cyc_gbl = 3'b000;
    stb_gbl = 3'b000;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs_rr[i]) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs_rr[i]);
      @(negedge clk);
      checkOutput(200 + i);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
